// File: rtl/prefetch_block_queue_if.sv
// rtl/prefetch_block_queue_if.sv - memory read request/response bus of the prefetch block queue
// The master is the queue issuing reads; the slave is the memory returning data in issue order.
interface prefetch_block_queue_if #(
   parameter int ADDR_BITS = 64,
   parameter int DATA_BITS = 64
);
   logic                 memReqValid;
   logic [ADDR_BITS-1:0] memReqAddr;
   logic                 memReqReady;
   logic                 memRespValid;
   logic [DATA_BITS-1:0] memRespData;

   modport master (
      output memReqValid, memReqAddr,
      input  memReqReady, memRespValid, memRespData
   );

   modport slave (
      input  memReqValid, memReqAddr,
      output memReqReady, memRespValid, memRespData
   );
endinterface

// File: rtl/prefetch_block_queue.sv
// rtl/prefetch_block_queue.sv - in-order prefetch address queue with read issue, fill and lookup
// Optional head-entry age timeout is enabled with the PFQ_TIMEOUT_EN macro.
module prefetch_block_queue #(
   parameter int ADDR_BITS       = 64,
   parameter int DATA_BITS       = 64,
   parameter int LOG_DEPTH       = 3,
   parameter int ALMOST_FULL_GAP = 1,
   parameter int TIMEOUT_CYCLES  = 256
) (
   input  logic                 clk,
   input  logic                 resetN,
   input  logic                 en,
   input  logic                 flushN,
   input  logic                 pushValid,
   input  logic [ADDR_BITS-1:0] pushAddr,
   output logic                 full,
   output logic                 empty,
   output logic                 almostFull,
   output logic [LOG_DEPTH:0]   outstandingReqCnt,
   prefetch_block_queue_if.master mem,
   input  logic                 lookupValid,
   input  logic [ADDR_BITS-1:0] lookupAddr,
   output logic                 lookupHit,
   output logic                 lookupPending,
   output logic [DATA_BITS-1:0] lookupData
);
   localparam int DEPTH = 1 << LOG_DEPTH;
   localparam int PTR_W = LOG_DEPTH + 1;

   logic [ADDR_BITS-1:0] addr_q [DEPTH];
   logic [DATA_BITS-1:0] data_q [DEPTH];

   logic [PTR_W-1:0] head_q, head_d, issue_q, issue_d, fill_q, fill_d, tail_q, tail_d;
   logic [PTR_W-1:0] cnt_q, cnt_d, drain_q, drain_d;
   logic             req_valid_q, req_valid_d, req_stale_q, req_stale_d;
   logic [ADDR_BITS-1:0] req_addr_q, req_addr_d;
   logic             hit_q, hit_d, pend_q, pend_d;
   logic [DATA_BITS-1:0] ldata_q, ldata_d;

   logic [PTR_W-1:0]     occ, filled_off, match_off;
   logic [LOG_DEPTH-1:0] scan_idx, match_idx;
   logic match_found, match_filled, pop_hit, push_ok, hs, resp_drain, timeout_pop;

   assign occ        = tail_q - head_q;
   assign filled_off = fill_q - head_q;
   assign full       = (occ == PTR_W'(DEPTH));
   assign empty      = (occ == '0);
   assign almostFull = ((PTR_W'(DEPTH) - occ) <= PTR_W'(ALMOST_FULL_GAP));

   assign outstandingReqCnt = cnt_q;
   assign mem.memReqValid   = req_valid_q;
   assign mem.memReqAddr    = req_addr_q;
   assign lookupHit         = hit_q;
   assign lookupPending     = pend_q;
   assign lookupData        = ldata_q;

   // Scan youngest to oldest so the oldest matching entry is the one kept.
   always_comb begin
      match_found = 1'b0;
      match_off   = '0;
      scan_idx    = '0;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         scan_idx = head_q[LOG_DEPTH-1:0] + LOG_DEPTH'(k);
         if ((PTR_W'(k) < occ) && (addr_q[scan_idx] == lookupAddr)) begin
            match_found = 1'b1;
            match_off   = PTR_W'(k);
         end
      end
   end

   assign match_idx    = head_q[LOG_DEPTH-1:0] + match_off[LOG_DEPTH-1:0];
   assign match_filled = (match_off < filled_off);
   assign pop_hit      = en & lookupValid & match_found & match_filled;
   assign push_ok      = en & pushValid & (~full | pop_hit);
   assign hs           = req_valid_q & mem.memReqReady;
   assign resp_drain   = mem.memRespValid & (drain_q != '0);

`ifdef PFQ_TIMEOUT_EN
   localparam int AGE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [AGE_W-1:0] age_q;
   logic             head_filled;

   assign head_filled = (head_q != fill_q);
   assign timeout_pop = head_filled & (age_q == AGE_W'(TIMEOUT_CYCLES - 1)) & ~pop_hit & flushN;

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         age_q <= '0;
      end else if (!flushN || (head_d != head_q)) begin
         age_q <= '0;
      end else if (head_filled) begin
         age_q <= age_q + 1'b1;
      end
   end
`else
   assign timeout_pop = 1'b0;
`endif

   always_comb begin
      head_d      = head_q;
      issue_d     = issue_q;
      fill_d      = fill_q;
      tail_d      = tail_q;
      req_valid_d = req_valid_q;
      req_addr_d  = req_addr_q;
      req_stale_d = req_stale_q;
      cnt_d       = cnt_q + PTR_W'(hs) - PTR_W'(mem.memRespValid);
      drain_d     = drain_q - PTR_W'(resp_drain) + PTR_W'(hs & req_stale_q);
      hit_d       = pop_hit;
      pend_d      = en & lookupValid & match_found & ~match_filled;
      ldata_d     = pop_hit ? data_q[match_idx] : '0;

      if (hs) begin
         req_valid_d = 1'b0;
         req_stale_d = 1'b0;
         if (!req_stale_q) issue_d = issue_q + 1'b1;
      end else if (!req_valid_q && en && flushN && (issue_q != tail_q)) begin
         req_valid_d = 1'b1;
         req_addr_d  = addr_q[issue_q[LOG_DEPTH-1:0]];
      end
      if (mem.memRespValid && !resp_drain) fill_d = fill_q + 1'b1;
      if (push_ok) tail_d = tail_q + 1'b1;
      if (pop_hit) head_d = head_q + match_off + 1'b1;
      else if (timeout_pop) head_d = head_q + 1'b1;

      // A request already on the bus is left to complete and is charged to the drain.
      if (!flushN) begin
         head_d      = '0;
         issue_d     = '0;
         fill_d      = '0;
         tail_d      = '0;
         drain_d     = cnt_d;
         req_stale_d = req_valid_q & ~hs;
         hit_d       = 1'b0;
         pend_d      = 1'b0;
         ldata_d     = '0;
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         head_q      <= '0;
         issue_q     <= '0;
         fill_q      <= '0;
         tail_q      <= '0;
         cnt_q       <= '0;
         drain_q     <= '0;
         req_valid_q <= 1'b0;
         req_addr_q  <= '0;
         req_stale_q <= 1'b0;
         hit_q       <= 1'b0;
         pend_q      <= 1'b0;
         ldata_q     <= '0;
      end else begin
         head_q      <= head_d;
         issue_q     <= issue_d;
         fill_q      <= fill_d;
         tail_q      <= tail_d;
         cnt_q       <= cnt_d;
         drain_q     <= drain_d;
         req_valid_q <= req_valid_d;
         req_addr_q  <= req_addr_d;
         req_stale_q <= req_stale_d;
         hit_q       <= hit_d;
         pend_q      <= pend_d;
         ldata_q     <= ldata_d;
      end
   end

   // Entry storage needs no reset: pointer ranges decide which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok && flushN) addr_q[tail_q[LOG_DEPTH-1:0]] <= pushAddr;
      if (mem.memRespValid && !resp_drain && flushN) data_q[fill_q[LOG_DEPTH-1:0]] <= mem.memRespData;
   end
endmodule

// File: tb/tb_prefetch_block_queue.sv
// tb/tb_prefetch_block_queue.sv - directed self-checking bench for prefetch_block_queue
module tb_prefetch_block_queue;
   logic        clk = 1'b0;
   logic        resetN, en, flushN, pushValid, lookupValid;
   logic [63:0] pushAddr, lookupAddr, lookupData;
   logic        full, empty, almostFull, lookupHit, lookupPending;
   logic [3:0]  outstandingReqCnt;
   int          checks = 0;
   int          passes = 0;

   prefetch_block_queue_if #(.ADDR_BITS(64), .DATA_BITS(64)) mif ();

   prefetch_block_queue #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .resetN(resetN), .en(en), .flushN(flushN),
      .pushValid(pushValid), .pushAddr(pushAddr),
      .full(full), .empty(empty), .almostFull(almostFull),
      .outstandingReqCnt(outstandingReqCnt), .mem(mif),
      .lookupValid(lookupValid), .lookupAddr(lookupAddr),
      .lookupHit(lookupHit), .lookupPending(lookupPending), .lookupData(lookupData)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [63:0] a);
      pushValid = 1'b1; pushAddr = a;
      tick();
      pushValid = 1'b0;
   endtask

   task automatic resp(input logic [63:0] d);
      mif.memRespValid = 1'b1; mif.memRespData = d;
      tick();
      mif.memRespValid = 1'b0;
   endtask

   task automatic lookup(input logic [63:0] a);
      lookupValid = 1'b1; lookupAddr = a;
      tick();
      lookupValid = 1'b0;
   endtask

   task automatic flush();
      flushN = 1'b0;
      tick();
      flushN = 1'b1;
   endtask

   task automatic test_reset();
      checks++; if (empty !== 1'b1) $display("FAIL rst_empty: got %0b exp 1", empty); else passes++;
      checks++; if (full !== 1'b0) $display("FAIL rst_full: got %0b exp 0", full); else passes++;
      checks++; if (almostFull !== 1'b0) $display("FAIL rst_af: got %0b exp 0", almostFull); else passes++;
      checks++; if (outstandingReqCnt !== 4'd0) $display("FAIL rst_cnt: got %0d exp 0", outstandingReqCnt); else passes++;
      checks++; if (mif.memReqValid !== 1'b0) $display("FAIL rst_reqv: got %0b exp 0", mif.memReqValid); else passes++;
      checks++; if (mif.memReqAddr !== 64'h0) $display("FAIL rst_reqa: got %0h exp 0", mif.memReqAddr); else passes++;
      checks++; if ({lookupHit, lookupPending} !== 2'b00) $display("FAIL rst_lookup: got %0b exp 00", {lookupHit, lookupPending}); else passes++;
      checks++; if (lookupData !== 64'h0) $display("FAIL rst_ldata: got %0h exp 0", lookupData); else passes++;
   endtask

   task automatic test_reset_midrun();
      mif.memReqReady = 1'b1;
      push(64'h500); push(64'h540); push(64'h580);
      for (int i = 0; i < 20 && outstandingReqCnt != 4'd2; i++) tick();
      checks++; if (outstandingReqCnt !== 4'd2) $display("FAIL mid_cnt_pre: got %0d exp 2", outstandingReqCnt); else passes++;
      resetN = 1'b0;
      tick();
      mif.memReqReady = 1'b0;
      checks++; if (empty !== 1'b1) $display("FAIL mid_empty: got %0b exp 1", empty); else passes++;
      checks++; if (outstandingReqCnt !== 4'd0) $display("FAIL mid_cnt: got %0d exp 0", outstandingReqCnt); else passes++;
      checks++; if (mif.memReqValid !== 1'b0) $display("FAIL mid_reqv: got %0b exp 0", mif.memReqValid); else passes++;
      resetN = 1'b1;
      tick();
   endtask

   task automatic test_issue_and_lookup();
      logic [63:0] a [3];
      logic [3:0]  c [3];
      logic [63:0] exp_a [3];
      int n = 0;
      exp_a[0] = 64'h1000; exp_a[1] = 64'h1040; exp_a[2] = 64'h1080;
      a[0] = '0; a[1] = '0; a[2] = '0; c[0] = '0; c[1] = '0; c[2] = '0;
      push(64'h1000); push(64'h1040); push(64'h1080);
      mif.memReqReady = 1'b1;
      for (int i = 0; i < 30 && n < 3; i++) begin
         if (mif.memReqValid) begin
            a[n] = mif.memReqAddr;
            tick();
            c[n] = outstandingReqCnt;
            n++;
         end else begin
            tick();
         end
      end
      mif.memReqReady = 1'b0;
      for (int j = 0; j < 3; j++) begin
         checks++; if (a[j] !== exp_a[j]) $display("FAIL issue_addr%0d: got %0h exp %0h", j, a[j], exp_a[j]); else passes++;
         checks++; if (c[j] !== 4'(j + 1)) $display("FAIL issue_cnt%0d: got %0d exp %0d", j, c[j], j + 1); else passes++;
      end
      resp(64'hD000);
      checks++; if (outstandingReqCnt !== 4'd2) $display("FAIL resp_cnt0: got %0d exp 2", outstandingReqCnt); else passes++;
      resp(64'hD001);
      checks++; if (outstandingReqCnt !== 4'd1) $display("FAIL resp_cnt1: got %0d exp 1", outstandingReqCnt); else passes++;
      resp(64'hD002);
      checks++; if (outstandingReqCnt !== 4'd0) $display("FAIL resp_cnt2: got %0d exp 0", outstandingReqCnt); else passes++;
      lookup(64'h1040);
      checks++; if (lookupHit !== 1'b1) $display("FAIL hit_1040: got %0b exp 1", lookupHit); else passes++;
      checks++; if (lookupData !== 64'hD001) $display("FAIL hit_data: got %0h exp d001", lookupData); else passes++;
      checks++; if (lookupPending !== 1'b0) $display("FAIL hit_pend: got %0b exp 0", lookupPending); else passes++;
      tick();
      checks++; if (lookupHit !== 1'b0) $display("FAIL hit_pulse: got %0b exp 0", lookupHit); else passes++;
      lookup(64'h1000);
      checks++; if ({lookupHit, lookupPending} !== 2'b00) $display("FAIL dropped_1000: got %0b exp 00", {lookupHit, lookupPending}); else passes++;
      lookup(64'h1080);
      checks++; if (lookupData !== 64'hD002) $display("FAIL hit_1080: got %0h exp d002", lookupData); else passes++;
      checks++; if (empty !== 1'b1) $display("FAIL occ_after_pops: got empty=%0b exp 1", empty); else passes++;
   endtask

   task automatic test_flush_drain();
      mif.memReqReady = 1'b1;
      push(64'h2000); push(64'h2040);
      for (int i = 0; i < 20 && outstandingReqCnt != 4'd2; i++) tick();
      mif.memReqReady = 1'b0;
      flush();
      checks++; if (empty !== 1'b1) $display("FAIL fl_empty: got %0b exp 1", empty); else passes++;
      checks++; if (outstandingReqCnt !== 4'd2) $display("FAIL fl_cnt: got %0d exp 2", outstandingReqCnt); else passes++;
      lookup(64'h2000);
      checks++; if ({lookupHit, lookupPending} !== 2'b00) $display("FAIL fl_lookup: got %0b exp 00", {lookupHit, lookupPending}); else passes++;
      resp(64'hE000);
      checks++; if (outstandingReqCnt !== 4'd1) $display("FAIL fl_drain1: got %0d exp 1", outstandingReqCnt); else passes++;
      resp(64'hE001);
      checks++; if (outstandingReqCnt !== 4'd0) $display("FAIL fl_drain2: got %0d exp 0", outstandingReqCnt); else passes++;
      checks++; if (empty !== 1'b1) $display("FAIL fl_empty2: got %0b exp 1", empty); else passes++;
   endtask

   task automatic test_full();
      for (int i = 0; i < 8; i++) begin
         push(64'h4000 + 64'(i) * 64'h40);
         if (i == 5) begin
            checks++; if (almostFull !== 1'b0) $display("FAIL af_at6: got %0b exp 0", almostFull); else passes++;
         end
         if (i == 6) begin
            checks++; if ({almostFull, full} !== 2'b10) $display("FAIL af_at7: got %0b exp 10", {almostFull, full}); else passes++;
         end
      end
      checks++; if ({almostFull, full} !== 2'b11) $display("FAIL full_at8: got %0b exp 11", {almostFull, full}); else passes++;
      push(64'h4900);
      checks++; if (full !== 1'b1) $display("FAIL full_9th: got %0b exp 1", full); else passes++;
      lookup(64'h4900);
      checks++; if ({lookupHit, lookupPending} !== 2'b00) $display("FAIL dropped_9th: got %0b exp 00", {lookupHit, lookupPending}); else passes++;
      checks++; if (mif.memReqAddr !== 64'h4000) $display("FAIL full_reqa: got %0h exp 4000", mif.memReqAddr); else passes++;
      mif.memReqReady = 1'b1;
      tick();
      mif.memReqReady = 1'b0;
      checks++; if (outstandingReqCnt !== 4'd1) $display("FAIL full_cnt: got %0d exp 1", outstandingReqCnt); else passes++;
      resp(64'hD0);
      pushValid = 1'b1; pushAddr = 64'h4a00; lookupValid = 1'b1; lookupAddr = 64'h4000;
      tick();
      pushValid = 1'b0; lookupValid = 1'b0;
      checks++; if ({lookupHit, lookupData} !== {1'b1, 64'hD0}) $display("FAIL pop_push_hit: got %0b/%0h exp 1/d0", lookupHit, lookupData); else passes++;
      checks++; if (full !== 1'b1) $display("FAIL pop_push_full: got %0b exp 1", full); else passes++;
      lookup(64'h4a00);
      checks++; if ({lookupHit, lookupPending} !== 2'b01) $display("FAIL pop_push_pend: got %0b exp 01", {lookupHit, lookupPending}); else passes++;
   endtask

   task automatic test_flush_held_req();
      checks++; if (mif.memReqValid !== 1'b1) $display("FAIL held_pre: got %0b exp 1", mif.memReqValid); else passes++;
      flush();
      checks++; if ({empty, mif.memReqValid} !== 2'b11) $display("FAIL held_kept: got %0b exp 11", {empty, mif.memReqValid}); else passes++;
      mif.memReqReady = 1'b1;
      for (int i = 0; i < 10 && outstandingReqCnt != 4'd1; i++) tick();
      mif.memReqReady = 1'b0;
      checks++; if (outstandingReqCnt !== 4'd1) $display("FAIL held_cnt: got %0d exp 1", outstandingReqCnt); else passes++;
      tick();
      checks++; if (mif.memReqValid !== 1'b0) $display("FAIL held_done: got %0b exp 0", mif.memReqValid); else passes++;
      resp(64'hBAD);
      checks++; if ({outstandingReqCnt, empty} !== {4'd0, 1'b1}) $display("FAIL held_drain: got %0d/%0b exp 0/1", outstandingReqCnt, empty); else passes++;
   endtask

   task automatic test_timeout();
      mif.memReqReady = 1'b1;
      push(64'h3000);
      for (int i = 0; i < 20 && outstandingReqCnt != 4'd1; i++) tick();
      mif.memReqReady = 1'b0;
      resp(64'hAB);
      tick(); tick(); tick();
      checks++; if (empty !== 1'b0) $display("FAIL to_early: got %0b exp 0", empty); else passes++;
      tick();
`ifdef PFQ_TIMEOUT_EN
      checks++; if (empty !== 1'b1) $display("FAIL to_popped: got %0b exp 1", empty); else passes++;
`else
      for (int i = 0; i < 10; i++) tick();
      checks++; if (empty !== 1'b0) $display("FAIL to_stays: got %0b exp 0", empty); else passes++;
      lookup(64'h3000);
      checks++; if ({lookupHit, lookupData} !== {1'b1, 64'hAB}) $display("FAIL to_hit: got %0b/%0h exp 1/ab", lookupHit, lookupData); else passes++;
`endif
   endtask

   initial begin
      resetN = 1'b0; en = 1'b1; flushN = 1'b1;
      pushValid = 1'b0; pushAddr = '0; lookupValid = 1'b0; lookupAddr = '0;
      mif.memReqReady = 1'b0; mif.memRespValid = 1'b0; mif.memRespData = '0;
      tick(); tick();
      test_reset();
      resetN = 1'b1;
      tick();
      test_reset_midrun();
      test_issue_and_lookup();
      test_flush_drain();
      test_full();
      test_flush_held_req();
      test_timeout();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
